writeback_regfile: RTL and testbench

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

---
 rtl/y86_pkg.sv | 41 ++++
 rtl/writeback_regfile_if.sv | 31 +++
 rtl/writeback_regfile_wb_dst_select.sv | 38 +++
 rtl/writeback_regfile.sv | 95 +++++++++
 tb/tb_writeback_regfile.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register IDs and status codes.
package y86_pkg;

    localparam int unsigned ICODE_W = 4;
    localparam int unsigned REG_ID_W = 4;
    localparam int unsigned STAT_W = 3;

    // Instruction codes carried down the pipeline
    typedef enum logic [ICODE_W-1:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_CMOVXX = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    // Instruction status codes
    typedef enum logic [STAT_W-1:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    // Register identifiers with architectural meaning
    localparam logic [REG_ID_W-1:0] RRSP  = 4'h4;
    localparam logic [REG_ID_W-1:0] RNONE = 4'hF;

    // True when a register ID names a real register (not RNONE)
    function automatic logic is_real_reg(input logic [REG_ID_W-1:0] id);
        return id != RNONE;
    endfunction

endpackage

// File: rtl/writeback_regfile_if.sv
// Writeback/decode bundle: writeback inputs, decode read ports and status back to the pipeline.
interface writeback_regfile_if #(
    parameter int unsigned WIDTH = 64
);
    logic [3:0]       icode;
    logic [3:0]       rA;
    logic [3:0]       rB;
    logic             cnd;
    logic [WIDTH-1:0] valE;
    logic [WIDTH-1:0] valM;
    logic [2:0]       stat;
    logic [3:0]       srcA;
    logic [3:0]       srcB;
    logic [WIDTH-1:0] rdA;
    logic [WIDTH-1:0] rdB;
    logic [3:0]       dstE;
    logic [3:0]       dstM;
    logic             halted;

    // Pipeline side: drives writeback fields and read addresses
    modport master (
        output icode, rA, rB, cnd, valE, valM, stat, srcA, srcB,
        input  rdA, rdB, dstE, dstM, halted
    );

    // Register file side
    modport slave (
        input  icode, rA, rB, cnd, valE, valM, stat, srcA, srcB,
        output rdA, rdB, dstE, dstM, halted
    );
endinterface

// File: rtl/writeback_regfile_wb_dst_select.sv
// Combinational writeback destination decode for the E and M write ports.
module wb_dst_select
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic [3:0] r_a,
    input  logic [3:0] r_b,
    input  logic       cnd,
    output logic [3:0] dst_e_c,
    output logic [3:0] dst_m_c
);

    // E port: ALU result destination; cmov only when the condition holds
    always_comb begin
        dst_e_c = RNONE;
        case (icode_e'(icode))
            I_CMOVXX: dst_e_c = cnd ? r_b : RNONE;
            I_IRMOVQ: dst_e_c = r_b;
            I_OPQ:    dst_e_c = r_b;
            I_CALL,
            I_RET,
            I_PUSHQ,
            I_POPQ:   dst_e_c = RRSP;
            default:  dst_e_c = RNONE;
        endcase
    end

    // M port: memory read destination
    always_comb begin
        dst_m_c = RNONE;
        case (icode_e'(icode))
            I_MRMOVQ: dst_m_c = r_a;
            I_POPQ:   dst_m_c = r_a;
            default:  dst_m_c = RNONE;
        endcase
    end

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 register file with dual writeback ports and sticky halt tracking.
module writeback_regfile
    import y86_pkg::*;
#(
    parameter int unsigned NREGS = 15,
    parameter int unsigned WIDTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    writeback_regfile_if.slave wb
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic             halted_q;
    logic             halted_d;
    logic [3:0]       dst_e_c;
    logic [3:0]       dst_m_c;
    logic             commit_c;
    logic [WIDTH-1:0] rd_a_c;
    logic [WIDTH-1:0] rd_b_c;

    wb_dst_select u_dst_select (
        .icode   (wb.icode),
        .r_a     (wb.rA),
        .r_b     (wb.rB),
        .cnd     (wb.cnd),
        .dst_e_c (dst_e_c),
        .dst_m_c (dst_m_c)
    );

    // An instruction commits only while running and with a clean status
    assign commit_c = !halted_q && (wb.stat == STAT_AOK);

    // Next register contents; M port applied last so it wins a shared destination
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (commit_c) begin
            for (int i = 0; i < NREGS; i++) begin
                if (is_real_reg(dst_e_c) && dst_e_c == 4'(i)) begin
                    regs_d[i] = wb.valE;
                end
                if (is_real_reg(dst_m_c) && dst_m_c == 4'(i)) begin
                    regs_d[i] = wb.valM;
                end
            end
        end
    end

    // Halt latches on any non-AOK status and holds until reset
    always_comb begin
        halted_d = halted_q;
        if (wb.stat != STAT_AOK) begin
            halted_d = 1'b1;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            halted_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            halted_q <= halted_d;
        end
    end

    // Combinational read ports; RNONE (and any unimplemented ID) reads zero
    always_comb begin
        rd_a_c = '0;
        rd_b_c = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (wb.srcA == 4'(i)) begin
                rd_a_c = regs_q[i];
            end
            if (wb.srcB == 4'(i)) begin
                rd_b_c = regs_q[i];
            end
        end
    end

    assign wb.rdA    = rd_a_c;
    assign wb.rdB    = rd_b_c;
    assign wb.dstE   = dst_e_c;
    assign wb.dstM   = dst_m_c;
    assign wb.halted = halted_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: vector table plus multi-cycle sequences.
module tb_writeback_regfile;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    writeback_regfile_if #(.WIDTH(64)) wb_if ();

    writeback_regfile #(.NREGS(15), .WIDTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        cnd;
        logic [63:0] val_e;
        logic [63:0] val_m;
        logic [2:0]  stat;
        logic [3:0]  src_a;
        logic [3:0]  src_b;
        logic [3:0]  exp_dst_e;
        logic [3:0]  exp_dst_m;
        logic [63:0] exp_rd_a;
        logic [63:0] exp_rd_b;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb,
                         input logic cnd, input logic [63:0] val_e, input logic [63:0] val_m,
                         input logic [2:0] stat, input logic [3:0] src_a, input logic [3:0] src_b);
        wb_if.icode = icode;
        wb_if.rA    = ra;
        wb_if.rB    = rb;
        wb_if.cnd   = cnd;
        wb_if.valE  = val_e;
        wb_if.valM  = val_m;
        wb_if.stat  = stat;
        wb_if.srcA  = src_a;
        wb_if.srcB  = src_b;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        // icode ra rb cnd valE valM stat srcA srcB | dstE dstM rdA rdB (after edge)
        vecs[0]  = '{4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0,   3'd1, 4'h2, 4'h3, 4'h2, 4'hF, 64'h1234, 64'h0};
        vecs[1]  = '{4'h2, 4'hF, 4'h5, 1'b0, 64'hAA,   64'h0,   3'd1, 4'h5, 4'h2, 4'hF, 4'hF, 64'h0,    64'h1234};
        vecs[2]  = '{4'h2, 4'hF, 4'h5, 1'b1, 64'hAA,   64'h0,   3'd1, 4'h5, 4'h2, 4'h5, 4'hF, 64'hAA,   64'h1234};
        vecs[3]  = '{4'hB, 4'h3, 4'hF, 1'b0, 64'h108,  64'h55,  3'd1, 4'h4, 4'h3, 4'h4, 4'h3, 64'h108,  64'h55};
        vecs[4]  = '{4'hB, 4'h4, 4'hF, 1'b0, 64'h108,  64'h77,  3'd1, 4'h4, 4'hF, 4'h4, 4'h4, 64'h77,   64'h0};
        vecs[5]  = '{4'h5, 4'h6, 4'h1, 1'b0, 64'hDEAD, 64'h600, 3'd1, 4'h6, 4'h1, 4'hF, 4'h6, 64'h600,  64'h0};
        vecs[6]  = '{4'h6, 4'h1, 4'h7, 1'b0, 64'h77,   64'h0,   3'd1, 4'h7, 4'hF, 4'h7, 4'hF, 64'h77,   64'h0};
        vecs[7]  = '{4'h8, 4'hF, 4'hF, 1'b0, 64'h100,  64'h0,   3'd1, 4'h4, 4'h6, 4'h4, 4'hF, 64'h100,  64'h600};
        vecs[8]  = '{4'h4, 4'h1, 4'h2, 1'b0, 64'h999,  64'h888, 3'd1, 4'h1, 4'h2, 4'hF, 4'hF, 64'h0,    64'h1234};
        vecs[9]  = '{4'h1, 4'h3, 4'h3, 1'b1, 64'h111,  64'h222, 3'd1, 4'hE, 4'h0, 4'hF, 4'hF, 64'h0,    64'h0};
        vecs[10] = '{4'h3, 4'hF, 4'hE, 1'b0, 64'hE,    64'h0,   3'd1, 4'hE, 4'h3, 4'hE, 4'hF, 64'hE,    64'h55};
        vecs[11] = '{4'hA, 4'h2, 4'hF, 1'b0, 64'hF8,   64'h0,   3'd1, 4'h4, 4'h7, 4'h4, 4'hF, 64'hF8,   64'h77};
        vecs[12] = '{4'h9, 4'hF, 4'hF, 1'b0, 64'h100,  64'hF0,  3'd1, 4'h4, 4'h5, 4'h4, 4'hF, 64'h100,  64'hAA};
        vecs[13] = '{4'h3, 4'hF, 4'hF, 1'b0, 64'h5A,   64'h0,   3'd1, 4'hF, 4'hE, 4'hF, 4'hF, 64'h0,    64'hE};

        // Reset state
        reset = 1'b1;
        drive(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 3'd1, 4'h2, 4'h4);
        #3;
        check("reset_rdA", wb_if.rdA, 64'h0);
        check("reset_rdB", wb_if.rdB, 64'h0);
        check("reset_halted", 64'(wb_if.halted), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Vector table: decode checked before the edge, reads after it
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].icode, vecs[i].ra, vecs[i].rb, vecs[i].cnd, vecs[i].val_e,
                  vecs[i].val_m, vecs[i].stat, vecs[i].src_a, vecs[i].src_b);
            #1;
            check($sformatf("v%0d_dstE", i), 64'(wb_if.dstE), 64'(vecs[i].exp_dst_e));
            check($sformatf("v%0d_dstM", i), 64'(wb_if.dstM), 64'(vecs[i].exp_dst_m));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_rdA", i), wb_if.rdA, vecs[i].exp_rd_a);
            check($sformatf("v%0d_rdB", i), wb_if.rdB, vecs[i].exp_rd_b);
            check($sformatf("v%0d_halted", i), 64'(wb_if.halted), 64'h0);
        end

        // No bypass: old value until the edge, new value after
        @(negedge clk);
        drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h1, 64'h0, 3'd1, 4'h2, 4'hF);
        @(posedge clk);
        @(negedge clk);
        drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h2, 64'h0, 3'd1, 4'h2, 4'hF);
        #1;
        check("bypass_before", wb_if.rdA, 64'h1);
        @(posedge clk);
        #1;
        check("bypass_after", wb_if.rdA, 64'h2);

        // Load reg7 ahead of halt/reset sequences
        @(negedge clk);
        drive(4'h3, 4'hF, 4'h7, 1'b0, 64'hFF, 64'h0, 3'd1, 4'h7, 4'hF);
        @(posedge clk);
        #1;
        check("reg7_load", wb_if.rdA, 64'hFF);

        // Halt: flag sets on the edge, later AOK instruction is blocked
        @(negedge clk);
        drive(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 3'd2, 4'h1, 4'h7);
        #1;
        check("halt_pre_edge", 64'(wb_if.halted), 64'h0);
        @(posedge clk);
        #1;
        check("halt_set", 64'(wb_if.halted), 64'h1);
        @(negedge clk);
        drive(4'h3, 4'hF, 4'h1, 1'b0, 64'h9, 64'h0, 3'd1, 4'h1, 4'h7);
        #1;
        check("halt_dstE_indep", 64'(wb_if.dstE), 64'h1);
        @(posedge clk);
        #1;
        check("halt_sticky", 64'(wb_if.halted), 64'h1);
        check("halt_no_write", wb_if.rdA, 64'h0);
        check("halt_reg7_kept", wb_if.rdB, 64'hFF);

        // Async reset between edges clears without a clock
        @(negedge clk);
        drive(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 3'd1, 4'h7, 4'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_rdA", wb_if.rdA, 64'h0);
        check("async_rst_halted", 64'(wb_if.halted), 64'h0);

        // Write presented while reset is high is lost
        drive(4'h3, 4'hF, 4'h3, 1'b0, 64'h33, 64'h0, 3'd1, 4'h3, 4'h7);
        @(posedge clk);
        #1;
        check("rst_write_lost", wb_if.rdA, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(4'h3, 4'hF, 4'h1, 1'b0, 64'h9, 64'h0, 3'd1, 4'h1, 4'h3);
        #1;
        check("post_rst_pre_edge", wb_if.rdA, 64'h0);

        // First edge after reset release commits
        @(posedge clk);
        #1;
        check("post_rst_commit", wb_if.rdA, 64'h9);
        check("post_rst_reg3", wb_if.rdB, 64'h0);
        check("post_rst_halted", 64'(wb_if.halted), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
